// File: rtl/sfp_ctrl.sv
// Row-sequencing FSM for a split-core normalizer: accumulate, sync with peer, exchange, divide.
// Define SFP_CTRL_TIMEOUT_EN to abort a stalled peer wait into DONE after TMO_CYC cycles.
module sfp_ctrl #(
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned TMO_CYC = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             psum_valid,
  output logic             psum_rd,
  output logic             acc,
  output logic             div,
  output logic             fifo_ext_rd,
  input  logic             peer_rdy_in,
  output logic             peer_rdy_out,
  output logic             sfp_wr,
  output logic             busy,
  output logic             done,
  output logic [2:0]       state,
  output logic             timeout
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StAcc  = 3'd1,
    StSync = 3'd2,
    StXchg = 3'd3,
    StDiv  = 3'd4,
    StDone = 3'd5
  } state_e;

  state_e         state_q, state_d;
  logic [LEN_W:0] cnt_q, cnt_d, cnt_inc;
  logic [LEN_W:0] len_q, len_d;
  logic           sfp_wr_q;

`ifdef SFP_CTRL_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TMO_CYC + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TMO_CYC - 1);
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            timeout_q, timeout_d;
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO_CYC;
`endif

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    acc          = 1'b0;
    div          = 1'b0;
    psum_rd      = 1'b0;
    fifo_ext_rd  = 1'b0;
    peer_rdy_out = 1'b0;
    done         = 1'b0;
`ifdef SFP_CTRL_TIMEOUT_EN
    tmo_d        = '0;
    timeout_d    = timeout_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          // len of zero encodes a full 2**LEN_W-row job
          len_d   = (len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len};
          cnt_d   = '0;
          state_d = StAcc;
`ifdef SFP_CTRL_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end
      end
      StAcc: begin
        acc     = psum_valid;
        psum_rd = psum_valid;
        if (psum_valid) begin
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) state_d = StSync;
        end
      end
      StSync: begin
        peer_rdy_out = 1'b1;
        if (peer_rdy_in) begin
          cnt_d   = '0;
          state_d = StXchg;
        end
`ifdef SFP_CTRL_TIMEOUT_EN
        else if (tmo_q == TmoLast) begin
          timeout_d = 1'b1;
          state_d   = StDone;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      StXchg: begin
        fifo_ext_rd = 1'b1;
        if (cnt_inc == len_q) begin
          cnt_d   = '0;
          state_d = StDiv;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StDiv: begin
        div     = psum_valid;
        psum_rd = psum_valid;
        if (psum_valid) begin
          if (cnt_inc == len_q) begin
            cnt_d   = '0;
            state_d = StDone;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      len_q    <= '0;
      sfp_wr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      sfp_wr_q <= div;
    end
  end

`ifdef SFP_CTRL_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign sfp_wr = sfp_wr_q;
  assign busy   = (state_q != StIdle);
  assign state  = state_q;

endmodule

// File: tb/tb_sfp_ctrl.sv
// Directed bench for sfp_ctrl: full jobs, gaps, peer stall, mid-job reset, busy start, timeout.
module tb_sfp_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] len = 4'd0;
  logic       psum_valid = 1'b0;
  logic       peer_rdy_in = 1'b0;
  logic       psum_rd, acc, div, fifo_ext_rd, peer_rdy_out, sfp_wr, busy, done, timeout;
  logic [2:0] state;

  sfp_ctrl #(.LEN_W(4), .TMO_CYC(64)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .psum_valid(psum_valid),
    .psum_rd(psum_rd), .acc(acc), .div(div), .fifo_ext_rd(fifo_ext_rd),
    .peer_rdy_in(peer_rdy_in), .peer_rdy_out(peer_rdy_out), .sfp_wr(sfp_wr), .busy(busy),
    .done(done), .state(state), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Per-job observations, cycle k=1 is the first cycle after the start edge
  int done_k, acc_first, acc_last, fifo_first;
  int n_acc, n_div, n_fifo, n_wr, n_rd, n_peer, n_excl, n_rdbad, n_wrbad, n_flowbad, n_tmo;
  int tmo_k1, n_fifo_sync;
  bit rst_hit;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input int l, input int toggle, input int peer_wait, input int xchg_start,
                         input int rst_div, input int budget);
    int   sync_seen;
    bit   injected;
    logic prev_div;
    done_k = -1; acc_first = -1; acc_last = -1; fifo_first = -1;
    n_acc = 0; n_div = 0; n_fifo = 0; n_wr = 0; n_rd = 0; n_peer = 0; n_excl = 0;
    n_rdbad = 0; n_wrbad = 0; n_flowbad = 0; n_tmo = 0; tmo_k1 = -1; n_fifo_sync = 0;
    rst_hit = 0; sync_seen = 0; injected = 0; prev_div = 1'b0;
    start = 1'b1; len = l[3:0]; psum_valid = 1'b0; peer_rdy_in = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      cyc();
      start = 1'b0;
      len = l[3:0];
      if (xchg_start != 0 && state == 3'd3 && !injected) begin
        start = 1'b1; len = 4'd1; injected = 1;
      end
      psum_valid  = (toggle != 0) ? k[0] : 1'b1;
      peer_rdy_in = (sync_seen >= peer_wait);
      reset       = (rst_div != 0 && state == 3'd4 && n_div == 1);
      #1;
      if (k == 1) tmo_k1 = int'(timeout);
      if (acc) begin n_acc++; if (acc_first < 0) acc_first = k; acc_last = k; end
      if (div) n_div++;
      if (fifo_ext_rd) begin n_fifo++; if (fifo_first < 0) fifo_first = k; end
      if (fifo_ext_rd && peer_rdy_out) n_fifo_sync++;
      if (sfp_wr) n_wr++;
      if (psum_rd) n_rd++;
      if (peer_rdy_out) n_peer++;
      if (timeout) n_tmo++;
      if (int'(acc) + int'(div) + int'(fifo_ext_rd) > 1) n_excl++;
      if (psum_rd && state != 3'd1 && state != 3'd4) n_rdbad++;
      if ((state == 3'd1 && (acc !== psum_valid || psum_rd !== psum_valid)) ||
          (state == 3'd4 && (div !== psum_valid || psum_rd !== psum_valid))) n_flowbad++;
      if (sfp_wr !== prev_div) n_wrbad++;
      prev_div = div;
      if (state == 3'd2) sync_seen++;
      if (reset) begin rst_hit = 1; break; end
      if (done) begin done_k = k; break; end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    #1;
    total++;
    if ({busy, acc, div, fifo_ext_rd, psum_rd, peer_rdy_out, sfp_wr, done, timeout, state} !== 12'd0) begin
      bad++; $display("FAIL reset_outputs: got %b want 0", {busy, acc, div, fifo_ext_rd, psum_rd,
                      peer_rdy_out, sfp_wr, done, timeout, state});
    end
    // start coincident with reset must be dropped
    reset = 1'b1; start = 1'b1; len = 4'd4;
    cyc();
    reset = 1'b0; start = 1'b0;
    cyc();
    total++;
    if (state !== 3'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL start_with_reset: state=%0d busy=%0d want 0 0", state, busy);
    end
  endtask

  task automatic test_basic();
    run_job(4, 0, 0, 0, 0, 100);
    total++; if (done_k != 14) begin bad++; $display("FAIL basic_latency: got %0d want 14", done_k); end
    total++; if (acc_first != 1 || acc_last != 4) begin
      bad++; $display("FAIL basic_acc_window: got %0d..%0d want 1..4", acc_first, acc_last); end
    total++; if (n_acc != 4 || n_fifo != 4 || n_div != 4 || n_wr != 4) begin
      bad++; $display("FAIL basic_counts: acc=%0d fifo=%0d div=%0d wr=%0d want 4 each",
                      n_acc, n_fifo, n_div, n_wr); end
    total++; if (fifo_first != 6) begin bad++; $display("FAIL basic_xchg_start: got %0d want 6", fifo_first); end
    total++; if (n_rd != 8 || n_peer != 1) begin
      bad++; $display("FAIL basic_rd_peer: rd=%0d peer=%0d want 8 1", n_rd, n_peer); end
    total++; if (n_excl != 0 || n_rdbad != 0 || n_wrbad != 0 || n_flowbad != 0) begin
      bad++; $display("FAIL basic_rules: excl=%0d rdbad=%0d wrbad=%0d flowbad=%0d want 0",
                      n_excl, n_rdbad, n_wrbad, n_flowbad); end
    cyc();
    total++;
    if ({busy, acc, div, fifo_ext_rd, psum_rd, peer_rdy_out, sfp_wr, done, state} !== 11'd0) begin
      bad++; $display("FAIL basic_idle_after: got %b want 0", {busy, acc, div, fifo_ext_rd, psum_rd,
                      peer_rdy_out, sfp_wr, done, state});
    end
  endtask

  task automatic test_len16_gaps();
    // valid only on odd cycles: ACC ends k=31, SYNC k=32, XCHG 33-48, DIV rows on odd k 49..79
    run_job(0, 1, 0, 0, 0, 200);
    total++; if (n_acc != 16 || n_fifo != 16 || n_div != 16) begin
      bad++; $display("FAIL len16_counts: acc=%0d fifo=%0d div=%0d want 16 each", n_acc, n_fifo, n_div); end
    total++; if (n_rd != 32) begin bad++; $display("FAIL len16_psum_rd: got %0d want 32", n_rd); end
    total++; if (done_k != 80) begin bad++; $display("FAIL len16_latency: got %0d want 80", done_k); end
    total++; if (n_excl != 0 || n_rdbad != 0 || n_wrbad != 0 || n_flowbad != 0) begin
      bad++; $display("FAIL len16_rules: excl=%0d rdbad=%0d wrbad=%0d flowbad=%0d want 0",
                      n_excl, n_rdbad, n_wrbad, n_flowbad); end
    cyc();
  endtask

  task automatic test_peer_wait();
    // peer_rdy_in sampled low on 9 SYNC edges, high on the 10th: SYNC spans k=3..12
    run_job(2, 0, 9, 0, 0, 100);
    total++; if (n_peer != 10) begin bad++; $display("FAIL peer_out_cycles: got %0d want 10", n_peer); end
    total++; if (n_fifo_sync != 0) begin bad++; $display("FAIL peer_fifo_in_wait: got %0d want 0", n_fifo_sync); end
    total++; if (fifo_first != 13 || done_k != 17) begin
      bad++; $display("FAIL peer_xchg_entry: fifo_first=%0d done=%0d want 13 17", fifo_first, done_k); end
    cyc();
  endtask

  task automatic test_reset_mid_div();
    run_job(3, 0, 0, 0, 1, 100);
    total++; if (!rst_hit) begin bad++; $display("FAIL rst_div_reached: got 0 want 1"); end
    cyc();
    reset = 1'b0;
    #1;
    total++;
    if ({busy, acc, div, fifo_ext_rd, psum_rd, peer_rdy_out, sfp_wr, done, timeout, state} !== 12'd0) begin
      bad++; $display("FAIL rst_div_outputs: got %b want 0", {busy, acc, div, fifo_ext_rd, psum_rd,
                      peer_rdy_out, sfp_wr, done, timeout, state});
    end
    run_job(2, 0, 0, 0, 0, 100);
    total++; if (done_k != 8 || n_div != 2 || n_wr != 2) begin
      bad++; $display("FAIL rst_div_rerun: done=%0d div=%0d wr=%0d want 8 2 2", done_k, n_div, n_wr); end
    cyc();
  endtask

  task automatic test_busy_start();
    int extra_done;
    run_job(4, 0, 0, 1, 0, 100);
    total++; if (done_k != 14 || n_div != 4) begin
      bad++; $display("FAIL busy_start_job: done=%0d div=%0d want 14 4", done_k, n_div); end
    extra_done = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (done || busy) extra_done++;
    end
    total++; if (extra_done != 0) begin bad++; $display("FAIL busy_start_extra: got %0d want 0", extra_done); end
  endtask

  task automatic test_timeout();
`ifdef SFP_CTRL_TIMEOUT_EN
    run_job(1, 0, 100000, 0, 0, 300);
    total++; if (done_k != 66 || n_peer != 64) begin
      bad++; $display("FAIL tmo_abort: done=%0d peer=%0d want 66 64", done_k, n_peer); end
    total++; if (n_div != 0 || n_fifo != 0) begin
      bad++; $display("FAIL tmo_skip: div=%0d fifo=%0d want 0 0", n_div, n_fifo); end
    cyc();
    total++; if (timeout !== 1'b1) begin bad++; $display("FAIL tmo_sticky: got %0d want 1", timeout); end
    run_job(1, 0, 0, 0, 0, 50);
    total++; if (tmo_k1 != 0 || done_k != 5) begin
      bad++; $display("FAIL tmo_clear: timeout=%0d done=%0d want 0 5", tmo_k1, done_k); end
`else
    // without the timeout option a long stall just waits: SYNC k=2..82
    run_job(1, 0, 80, 0, 0, 200);
    total++; if (done_k != 85 || n_peer != 81) begin
      bad++; $display("FAIL long_wait: done=%0d peer=%0d want 85 81", done_k, n_peer); end
    total++; if (n_tmo != 0) begin bad++; $display("FAIL timeout_tied: got %0d want 0", n_tmo); end
`endif
    cyc();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len16_gaps();
    test_peer_wait();
    test_reset_mid_div();
    test_busy_start();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
